// File: rtl/prbs_training_checker.sv
// Receive-side PRBS15 (XNOR) checker: decimates ADC samples, slices, self-syncs, counts bits/errors.
// Optional inverted-polarity lock search is built in when PRBS_CHECK_POLARITY_EN is defined.
module prbs_training_checker #(
    parameter int ADC_WIDTH    = 16,
    parameter int COUNT_WIDTH  = 32,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_LEVEL = 64
) (
    input  logic                        adcClk_i,
    input  logic                        adcReset_i,
    input  logic                        enable_i,
    input  logic                        clearCounters_i,
    input  logic [7:0]                  samplesPerBit_i,
    input  logic [7:0]                  samplePhase_i,
    input  logic signed [ADC_WIDTH-1:0] threshold_i,
    input  logic                        sampleValid_i,
    input  logic signed [ADC_WIDTH-1:0] sampleData_i,
    output logic                        locked_o,
    output logic                        polarityInverted_o,
    output logic [COUNT_WIDTH-1:0]      bitCount_o,
    output logic [COUNT_WIDTH-1:0]      errorCount_o,
    output logic [COUNT_WIDTH-1:0]      lockLossCount_o
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int LVL_W = $clog2(UNLOCK_LEVEL + 4) + 1;

    typedef enum logic [1:0] {IDLE, FILL, SEARCH, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             phaseCnt_q, phaseCnt_d;
    logic [7:0]             spbEff;
    logic                   bitValid_q, bitValid_d;
    logic                   bitData_q, bitData_d;
    logic [14:0]            ref_q, ref_d;
    logic [3:0]             fillCnt_q, fillCnt_d;
    logic [RUN_W-1:0]       run_q, run_d, runNext;
    logic [LVL_W-1:0]       level_q, level_d, levelNext;
    logic [COUNT_WIDTH-1:0] bitCount_q, bitCount_d;
    logic [COUNT_WIDTH-1:0] errorCount_q, errorCount_d;
    logic [COUNT_WIDTH-1:0] lossCount_q, lossCount_d;
    logic                   incBit, incErr, incLoss;
    logic                   predicted, expectedBit, mismatch, matchNorm;
`ifdef PRBS_CHECK_POLARITY_EN
    logic                   polInv_q, polInv_d;
    logic [RUN_W-1:0]       runInv_q, runInv_d, runInvNext;
    logic                   matchInv;
`endif

    // Decimation and slicing: one registered bit per bit period, taken at samplePhase.
    always_comb begin
        spbEff     = (samplesPerBit_i == 8'd0) ? 8'd1 : samplesPerBit_i;
        phaseCnt_d = phaseCnt_q;
        bitValid_d = 1'b0;
        bitData_d  = (sampleData_i >= threshold_i);
        if (!enable_i) begin
            phaseCnt_d = 8'd0;
        end else if (sampleValid_i) begin
            bitValid_d = (phaseCnt_q == samplePhase_i);
            phaseCnt_d = (phaseCnt_q >= spbEff - 8'd1) ? 8'd0 : phaseCnt_q + 8'd1;
        end
    end

    always_comb begin
        predicted = ~(ref_q[14] ^ ref_q[13]);
`ifdef PRBS_CHECK_POLARITY_EN
        expectedBit = predicted ^ polInv_q;
        matchInv    = (bitData_q != predicted) && (ref_q != '0);
        runInvNext  = runInv_q + RUN_W'(1);
        polInv_d    = polInv_q;
        runInv_d    = runInv_q;
`else
        expectedBit = predicted;
`endif
        mismatch  = (bitData_q != expectedBit);
        matchNorm = (bitData_q == predicted) && (ref_q != '1);
        runNext   = run_q + RUN_W'(1);
        levelNext = level_q;
        state_d   = state_q;
        ref_d     = ref_q;
        fillCnt_d = fillCnt_q;
        run_d     = run_q;
        level_d   = level_q;
        incBit    = 1'b0;
        incErr    = 1'b0;
        incLoss   = 1'b0;
        if (!enable_i) begin
            state_d   = IDLE;
            fillCnt_d = 4'd0;
            run_d     = '0;
`ifdef PRBS_CHECK_POLARITY_EN
            polInv_d  = 1'b0;
            runInv_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: state_d = FILL;
                FILL: begin
                    if (bitValid_q) begin
                        ref_d = {ref_q[13:0], bitData_q};
                        if (fillCnt_q == 4'd14) begin
                            state_d   = SEARCH;
                            fillCnt_d = 4'd0;
                            run_d     = '0;
`ifdef PRBS_CHECK_POLARITY_EN
                            runInv_d  = '0;
`endif
                        end else begin
                            fillCnt_d = fillCnt_q + 4'd1;
                        end
                    end
                end
                SEARCH: begin
                    if (bitValid_q) begin
                        ref_d = {ref_q[13:0], bitData_q};
                        run_d = matchNorm ? runNext : '0;
`ifdef PRBS_CHECK_POLARITY_EN
                        runInv_d = matchInv ? runInvNext : '0;
`endif
                        if (matchNorm && runNext == RUN_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            level_d = '0;
                        end
`ifdef PRBS_CHECK_POLARITY_EN
                        else if (matchInv && runInvNext == RUN_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            level_d  = '0;
                            polInv_d = 1'b1;
                        end
`endif
                    end
                end
                LOCKED: begin
                    // The reference free-runs on its own prediction so one bad bit costs one error.
                    if (bitValid_q) begin
                        ref_d  = {ref_q[13:0], expectedBit};
                        incBit = 1'b1;
                        if (mismatch) begin
                            incErr    = 1'b1;
                            levelNext = level_q + LVL_W'(4);
                        end else if (level_q != '0) begin
                            levelNext = level_q - LVL_W'(1);
                        end
                        level_d = levelNext;
                        if (levelNext >= LVL_W'(UNLOCK_LEVEL)) begin
                            state_d   = FILL;
                            fillCnt_d = 4'd0;
                            run_d     = '0;
                            incLoss   = 1'b1;
`ifdef PRBS_CHECK_POLARITY_EN
                            polInv_d  = 1'b0;
                            runInv_d  = '0;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        bitCount_d   = bitCount_q;
        errorCount_d = errorCount_q;
        lossCount_d  = lossCount_q;
        if (clearCounters_i) begin
            bitCount_d   = '0;
            errorCount_d = '0;
            lossCount_d  = '0;
        end else begin
            if (incBit && bitCount_q != '1)    bitCount_d   = bitCount_q + COUNT_WIDTH'(1);
            if (incErr && errorCount_q != '1)  errorCount_d = errorCount_q + COUNT_WIDTH'(1);
            if (incLoss && lossCount_q != '1)  lossCount_d  = lossCount_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge adcClk_i) begin
        if (adcReset_i) begin
            state_q      <= IDLE;
            phaseCnt_q   <= 8'd0;
            bitValid_q   <= 1'b0;
            bitData_q    <= 1'b0;
            ref_q        <= '0;
            fillCnt_q    <= 4'd0;
            run_q        <= '0;
            level_q      <= '0;
            bitCount_q   <= '0;
            errorCount_q <= '0;
            lossCount_q  <= '0;
`ifdef PRBS_CHECK_POLARITY_EN
            polInv_q     <= 1'b0;
            runInv_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phaseCnt_q   <= phaseCnt_d;
            bitValid_q   <= bitValid_d;
            bitData_q    <= bitData_d;
            ref_q        <= ref_d;
            fillCnt_q    <= fillCnt_d;
            run_q        <= run_d;
            level_q      <= level_d;
            bitCount_q   <= bitCount_d;
            errorCount_q <= errorCount_d;
            lossCount_q  <= lossCount_d;
`ifdef PRBS_CHECK_POLARITY_EN
            polInv_q     <= polInv_d;
            runInv_q     <= runInv_d;
`endif
        end
    end

    assign locked_o        = (state_q == LOCKED);
    assign bitCount_o      = bitCount_q;
    assign errorCount_o    = errorCount_q;
    assign lockLossCount_o = lossCount_q;
`ifdef PRBS_CHECK_POLARITY_EN
    assign polarityInverted_o = polInv_q;
`else
    assign polarityInverted_o = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_training_checker.sv
// Directed testbench for prbs_training_checker: lock, errors, loss/relock, stuck inputs, boundaries.
// Polarity expectations follow PRBS_CHECK_POLARITY_EN.
module tb_prbs_training_checker;
    logic               adcClk = 1'b0;
    logic               adcReset, enable, clearCounters, sampleValid;
    logic [7:0]         samplesPerBit, samplePhase;
    logic signed [15:0] threshold, sampleData;
    logic               locked, polarityInverted;
    logic [31:0]        bitCount, errorCount, lockLossCount;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] txRef;
    longint      expBits, expErrs;

    typedef struct {
        logic               valid;
        logic signed [15:0] hiVal;
        logic signed [15:0] loVal;
        logic signed [15:0] thr;
        int                 expErr;
    } vec_t;
    vec_t vecs[9];

    always #5 adcClk = ~adcClk;

    prbs_training_checker dut (
        .adcClk_i(adcClk), .adcReset_i(adcReset), .enable_i(enable),
        .clearCounters_i(clearCounters), .samplesPerBit_i(samplesPerBit),
        .samplePhase_i(samplePhase), .threshold_i(threshold),
        .sampleValid_i(sampleValid), .sampleData_i(sampleData),
        .locked_o(locked), .polarityInverted_o(polarityInverted),
        .bitCount_o(bitCount), .errorCount_o(errorCount),
        .lockLossCount_o(lockLossCount)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge adcClk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input int val);
        sampleValid = valid;
        sampleData  = 16'(val);
        tick();
    endtask

    task automatic nextTx(output logic b);
        b     = ~(txRef[14] ^ txRef[13]);
        txRef = {txRef[13:0], b};
    endtask

    task automatic sendBit(input logic b, input int spb);
        for (int i = 0; i < ((spb == 0) ? 1 : spb); i++) applyStimulus(1'b1, b ? 1000 : -1000);
    endtask

    task automatic sendPrbs(input int n, input int spb);
        logic b;
        for (int i = 0; i < n; i++) begin
            nextTx(b);
            sendBit(b, spb);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_bitCount"}, bitCount, expBits);
        checkOutput({tag, "_errorCount"}, errorCount, expErrs);
    endtask

    initial begin
        logic b, rb, lost, sawLock;
        int   n;

        vecs[0] = '{1'b1, 16'sd100, 16'sd99, 16'sd100, 0};
        vecs[1] = '{1'b1, -16'sd50, -16'sd51, -16'sd50, 0};
        vecs[2] = '{1'b1, 16'sd0, -16'sd1, 16'sd0, 0};
        vecs[3] = '{1'b0, 16'sd100, -16'sd100, 16'sd0, 0};
        vecs[4] = '{1'b1, 16'sd32767, -16'sd32768, -16'sd32767, 0};
        vecs[5] = '{1'b1, -16'sd1, 16'sd0, 16'sd0, 1};
        vecs[6] = '{1'b1, 16'sd5, 16'sd6, 16'sd6, 1};
        vecs[7] = '{1'b1, 16'sd32767, -16'sd32768, 16'sd32767, 0};
        vecs[8] = '{1'b1, 16'sd1000, -16'sd1000, 16'sd0, 0};

        adcReset = 1'b1; enable = 1'b0; clearCounters = 1'b0; sampleValid = 1'b0;
        samplesPerBit = 8'd4; samplePhase = 8'd2; threshold = 16'sd0; sampleData = 16'sd0;
        repeat (3) tick();
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_polInv", polarityInverted, 0);
        checkOutput("reset_bitCount", bitCount, 0);
        checkOutput("reset_errorCount", errorCount, 0);
        checkOutput("reset_lockLoss", lockLossCount, 0);
        adcReset = 1'b0;
        tick();

        // Lock at 4 samples/bit, phase 2: 15 fill + 64 matching bits.
        txRef = '0; enable = 1'b1;
        sendPrbs(78, 4);
        checkOutput("lock_before79", locked, 0);
        nextTx(b);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, b ? 1000 : -1000);
        checkOutput("lock_plus1cycle", locked, 0);
        applyStimulus(1'b1, b ? 1000 : -1000);
        checkOutput("lock_plus2cycles", locked, 1);
        expBits = 0; expErrs = 0;
        checkCounters("at_lock");
        sendPrbs(1000, 4);
        expBits = 1000;
        checkCounters("after1000");
        checkOutput("after1000_locked", locked, 1);

        // One flipped bit produces exactly one error.
        nextTx(b);
        sendBit(~b, 4);
        sendPrbs(20, 4);
        expBits += 21; expErrs = 1;
        checkCounters("single_err");
        checkOutput("single_err_locked", locked, 1);

        // clearCounters on the same edge that would count an error.
        nextTx(b);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, b ? -1000 : 1000);
        clearCounters = 1'b1;
        applyStimulus(1'b1, b ? -1000 : 1000);
        clearCounters = 1'b0;
        expBits = 0; expErrs = 0;
        checkCounters("clear_coincident");
        checkOutput("clear_locked", locked, 1);
        sendPrbs(10, 4);
        expBits = 10;
        checkCounters("after_clear");

        // samplePhase beyond the bit period yields no bits.
        samplePhase = 8'd5;
        for (int i = 0; i < 50; i++) sendBit(i[0], 4);
        checkCounters("phase_out_of_range");
        checkOutput("phase_oor_locked", locked, 1);
        samplePhase = 8'd2;
        sendPrbs(10, 4);
        expBits += 10;
        checkCounters("phase_restored");

        // Random data while locked must drop lock.
        lost = 1'b0; n = 0;
        while (!lost && n < 200) begin
            nextTx(b);
            rb = 1'($urandom_range(0, 1));
            sendBit(rb, 4);
            n++; expBits++;
            if (rb != b) expErrs++;
            if (!locked) lost = 1'b1;
        end
        checkOutput("loss_seen", lost, 1);
        checkOutput("loss_lockLossCount", lockLossCount, 1);
        checkCounters("loss");

        sendPrbs(78, 4);
        checkOutput("relock_before", locked, 0);
        sendPrbs(1, 4);
        checkOutput("relock", locked, 1);
        checkOutput("relock_lockLossCount", lockLossCount, 1);
        checkCounters("relock");

        // Enable low while locked: IDLE, counters frozen.
        enable = 1'b0;
        applyStimulus(1'b1, 1000);
        checkOutput("disable_locked", locked, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, i[0] ? 1000 : -1000);
        checkCounters("disable_hold");
        checkOutput("disable_lockLoss", lockLossCount, 1);

        // Reset mid-operation, then stuck inputs at one sample per bit.
        enable = 1'b1; adcReset = 1'b1;
        applyStimulus(1'b0, 0);
        adcReset = 1'b0;
        checkOutput("midreset_bitCount", bitCount, 0);
        checkOutput("midreset_lockLoss", lockLossCount, 0);
        samplesPerBit = 8'd0; samplePhase = 8'd0;
        sawLock = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'b1, 1000);
            sawLock |= locked;
        end
        checkOutput("stuck_high_nolock", sawLock, 0);
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'b1, -1000);
            sawLock |= locked;
        end
        checkOutput("stuck_low_nolock", sawLock, 0);

        // samplesPerBit = 0 behaves as one bit per valid sample.
        enable = 1'b0;
        applyStimulus(1'b0, 0);
        enable = 1'b1; txRef = '0;
        sendPrbs(79, 0);
        checkOutput("spb0_lock_early", locked, 0);
        applyStimulus(1'b0, 0);
        checkOutput("spb0_lock", locked, 1);
        expBits = 0; expErrs = 0;
        sendPrbs(100, 0);
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        expBits = 100;
        checkCounters("spb0_count");

        // Slicing vectors against a locked reference.
        for (int k = 0; k < 9; k++) begin
            b = 1'b0;
            if (vecs[k].valid) nextTx(b);
            threshold = vecs[k].thr;
            applyStimulus(vecs[k].valid, b ? int'(vecs[k].hiVal) : int'(vecs[k].loVal));
            applyStimulus(1'b0, 0);
            applyStimulus(1'b0, 0);
            if (vecs[k].valid) expBits++;
            expErrs += vecs[k].expErr;
            checkCounters($sformatf("vec%0d", k));
        end
        threshold = 16'sd0;
        checkOutput("vec_locked", locked, 1);

        // Inverted PRBS.
        enable = 1'b0; adcReset = 1'b1;
        applyStimulus(1'b0, 0);
        adcReset = 1'b0; enable = 1'b1; txRef = '0;
        for (int i = 0; i < 79; i++) begin
            nextTx(b);
            applyStimulus(1'b1, b ? -1000 : 1000);
        end
`ifdef PRBS_CHECK_POLARITY_EN
        checkOutput("inv_lock_early", locked, 0);
        applyStimulus(1'b0, 0);
        checkOutput("inv_locked", locked, 1);
        checkOutput("inv_polarity", polarityInverted, 1);
        for (int i = 0; i < 100; i++) begin
            nextTx(b);
            applyStimulus(1'b1, b ? -1000 : 1000);
        end
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        checkOutput("inv_bitCount", bitCount, 100);
        checkOutput("inv_errorCount", errorCount, 0);
        enable = 1'b0;
        applyStimulus(1'b0, 0);
        checkOutput("inv_polarity_cleared", polarityInverted, 0);
`else
        sawLock = locked;
        for (int i = 0; i < 300; i++) begin
            nextTx(b);
            applyStimulus(1'b1, b ? -1000 : 1000);
            sawLock |= locked;
        end
        checkOutput("inv_nolock", sawLock, 0);
        checkOutput("inv_polarity", polarityInverted, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
